// File: rtl/brr_block_encoder.sv
// BRR block encoder: collects 16 signed PCM samples, searches for the
// smallest arithmetic shift that fits every sample into a signed nibble,
// and writes one header byte plus eight packed data bytes to RAM.
module brr_block_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] start_address,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        last_block,
    input  logic        loop_flag,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_wdata,
    output logic        ram_write_request,
    output logic        busy,
    output logic        done,
    output logic [7:0]  block_count
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_COLLECT      = 3'd1,
        S_SEARCH       = 3'd2,
        S_WRITE_HEADER = 3'd3,
        S_WRITE_DATA   = 3'd4
    } state_t;

    localparam logic [3:0] MAX_SHIFT = 4'd12;

    state_t             state_q, state_d;
    logic [15:0]        ptr_q, ptr_d;
    logic [7:0]         block_count_q, block_count_d;
    logic [3:0]         sample_idx_q, sample_idx_d;
    logic signed [15:0] max_q, max_d;
    logic signed [15:0] min_q, min_d;
    logic [3:0]         shift_q, shift_d;
    logic               end_q, end_d;
    logic               loop_q, loop_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic               done_q, done_d;
    logic [15:0]        addr_hold_q, addr_hold_d;
    logic [7:0]         wdata_hold_q, wdata_hold_d;

    // Sample storage; contents only matter after a full block is collected,
    // so it carries no reset.
    logic signed [15:0] samples_q [16];
    logic               sample_we;

    logic signed [15:0] sample_s;
    logic signed [15:0] max_sh;
    logic signed [15:0] min_sh;
    logic               fits;
    logic               write_en;
    logic [7:0]         header_byte;
    logic [7:0]         wr_byte;
    logic [3:0]         nib       [16];
    logic [7:0]         data_byte [8];

    assign sample_s = sample_in;

    // Shifted block extremes decide whether the current shift is sufficient.
    assign max_sh = max_q >>> shift_q;
    assign min_sh = min_q >>> shift_q;
    assign fits   = (max_sh <= 16'sd7) && (min_sh >= -16'sd8);

    // Per-sample shifted and clamped nibble. With 16-bit input the clamp can
    // only engage if the shift stops short of the data range.
    for (genvar gi = 0; gi < 16; gi++) begin : g_nib
        logic signed [15:0] sh;
        assign sh      = samples_q[gi] >>> shift_q;
        assign nib[gi] = (sh > 16'sd7)  ? 4'h7 :
                         (sh < -16'sd8) ? 4'h8 :
                         sh[3:0];
    end

    // Data byte k packs samples 2k (high nibble) and 2k+1 (low nibble).
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
        assign data_byte[gi] = {nib[2*gi], nib[2*gi+1]};
    end

    assign header_byte = {shift_q, 2'b00, end_q & loop_q, end_q};
    assign write_en    = (state_q == S_WRITE_HEADER) || (state_q == S_WRITE_DATA);
    assign wr_byte     = (state_q == S_WRITE_HEADER) ? header_byte : data_byte[byte_idx_q];

    // RAM bus shows the live write while writing, otherwise the last written value.
    assign ram_write_request = write_en;
    assign ram_address       = write_en ? ptr_q   : addr_hold_q;
    assign ram_wdata         = write_en ? wr_byte : wdata_hold_q;

    assign sample_ready = (state_q == S_COLLECT);
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign block_count  = block_count_q;

    // Next-state and datapath updates for the encoder sequence.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        block_count_d = block_count_q;
        sample_idx_d  = sample_idx_q;
        max_d         = max_q;
        min_d         = min_q;
        shift_d       = shift_q;
        end_d         = end_q;
        loop_d        = loop_q;
        byte_idx_d    = byte_idx_q;
        done_d        = 1'b0;
        sample_we     = 1'b0;
        addr_hold_d   = write_en ? ptr_q   : addr_hold_q;
        wdata_hold_d  = write_en ? wr_byte : wdata_hold_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d         = start_address;
                    block_count_d = 8'd0;
                    sample_idx_d  = 4'd0;
                    state_d       = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (sample_valid) begin
                    sample_we = 1'b1;
                    if (sample_idx_q == 4'd0) begin
                        max_d = sample_s;
                        min_d = sample_s;
                    end else begin
                        if (sample_s > max_q) begin
                            max_d = sample_s;
                        end
                        if (sample_s < min_q) begin
                            min_d = sample_s;
                        end
                    end
                    // Index wraps to 0 after the 16th sample, ready for the next block.
                    sample_idx_d = sample_idx_q + 4'd1;
                    if (sample_idx_q == 4'd15) begin
                        end_d   = last_block;
                        loop_d  = loop_flag;
                        shift_d = 4'd0;
                        state_d = S_SEARCH;
                    end
                end
            end

            S_SEARCH: begin
                if (fits || (shift_q == MAX_SHIFT)) begin
                    state_d = S_WRITE_HEADER;
                end else begin
                    shift_d = shift_q + 4'd1;
                end
            end

            S_WRITE_HEADER: begin
                ptr_d      = ptr_q + 16'd1;
                byte_idx_d = 3'd0;
                state_d    = S_WRITE_DATA;
            end

            S_WRITE_DATA: begin
                ptr_d      = ptr_q + 16'd1;
                byte_idx_d = byte_idx_q + 3'd1;
                if (byte_idx_q == 3'd7) begin
                    block_count_d = block_count_q + 8'd1;
                    if (end_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers, reset to an idle, zeroed encoder.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= 16'd0;
            block_count_q <= 8'd0;
            sample_idx_q  <= 4'd0;
            max_q         <= 16'sd0;
            min_q         <= 16'sd0;
            shift_q       <= 4'd0;
            end_q         <= 1'b0;
            loop_q        <= 1'b0;
            byte_idx_q    <= 3'd0;
            done_q        <= 1'b0;
            addr_hold_q   <= 16'd0;
            wdata_hold_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            block_count_q <= block_count_d;
            sample_idx_q  <= sample_idx_d;
            max_q         <= max_d;
            min_q         <= min_d;
            shift_q       <= shift_d;
            end_q         <= end_d;
            loop_q        <= loop_d;
            byte_idx_q    <= byte_idx_d;
            done_q        <= done_d;
            addr_hold_q   <= addr_hold_d;
            wdata_hold_q  <= wdata_hold_d;
        end
    end

    // Sample storage write, suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (sample_we && !reset) begin
            samples_q[sample_idx_q] <= sample_s;
        end
    end

endmodule

// File: tb/tb_brr_block_encoder.sv
// Directed testbench for brr_block_encoder: hand-computed RAM write images,
// latencies and status outputs for each scenario.
module tb_brr_block_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] start_address;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        last_block;
    logic        loop_flag;
    logic [15:0] ram_address;
    logic [7:0]  ram_wdata;
    logic        ram_write_request;
    logic        busy;
    logic        done;
    logic [7:0]  block_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic [15:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    int          wr_cyc  [$];
    logic [15:0] blk [16];
    logic [7:0]  exp_bytes [9];

    brr_block_encoder dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .start_address     (start_address),
        .sample_in         (sample_in),
        .sample_valid      (sample_valid),
        .sample_ready      (sample_ready),
        .last_block        (last_block),
        .loop_flag         (loop_flag),
        .ram_address       (ram_address),
        .ram_wdata         (ram_wdata),
        .ram_write_request (ram_write_request),
        .busy              (busy),
        .done              (done),
        .block_count       (block_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Log every RAM write mid-cycle, one line per write.
    always @(negedge clock) begin
        if (ram_write_request === 1'b1) begin
            wr_addr.push_back(ram_address);
            wr_data.push_back(ram_wdata);
            wr_cyc.push_back(cyc);
            $display("write cyc=%0d addr=%h data=%h", cyc, ram_address, ram_wdata);
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic start_enc(input logic [15:0] addr);
        @(posedge clock); #1;
        start = 1'b1;
        start_address = addr;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic drive_sample(input logic [15:0] v, input logic lb, input logic lf);
        bit got;
        got = 1'b0;
        sample_valid = 1'b0;
        @(posedge clock); #1;
        sample_in    = v;
        sample_valid = 1'b1;
        last_block   = lb;
        loop_flag    = lf;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clock);
            if (sample_ready === 1'b1) begin
                accept_cyc = cyc;
                got = 1'b1;
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL sample_accept: sample_ready never seen, required 1");
        end
        @(posedge clock); #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_block(input logic lb, input logic lf);
        for (int i = 0; i < 16; i++) begin
            drive_sample(blk[i], lb, lf);
        end
    endtask

    task automatic wait_writes(input int n);
        int t;
        t = 0;
        while (wr_addr.size() < n && t < 400) begin
            @(negedge clock); #1;
            t++;
        end
        checks++;
        if (wr_addr.size() < n) begin
            errors++;
            $display("FAIL write_count: got %0d writes, required %0d", wr_addr.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL reset_sample_ready: got %b required 0", sample_ready); end
        checks++; if (ram_write_request !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b required 0", ram_write_request); end
        checks++; if (ram_address !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h required 0000", ram_address); end
        checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h required 00", ram_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (block_count !== 8'd0) begin errors++; $display("FAIL reset_block_count: got %0d required 0", block_count); end
        @(posedge clock); #1;
        reset = 1'b0;
        $display("test_reset complete");
    endtask

    task automatic test_zero_block();
        logic [15:0] ea;
        clear_log();
        start_enc(16'h0200);
        for (int i = 0; i < 16; i++) blk[i] = 16'h0000;
        send_block(1'b1, 1'b0);
        wait_writes(9);
        for (int k = 0; k < 9; k++) begin
            ea = 16'h0200 + 16'(k);
            exp_bytes[k] = (k == 0) ? 8'h01 : 8'h00;
            checks++;
            if (wr_addr[k] !== ea || wr_data[k] !== exp_bytes[k]) begin
                errors++;
                $display("FAIL zero_block_byte%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea, exp_bytes[k]);
            end
        end
        checks++;
        if (wr_cyc[8] !== accept_cyc + 10) begin errors++; $display("FAIL zero_block_latency: got %0d required %0d", wr_cyc[8] - accept_cyc, 10); end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_block_done: got %b required 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_block_busy: got %b required 0", busy); end
        checks++; if (block_count !== 8'd1) begin errors++; $display("FAIL zero_block_count: got %0d required 1", block_count); end
        @(negedge clock); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_block_done_pulse: got %b required 0", done); end
        $display("test_zero_block complete");
    endtask

    task automatic test_alternating();
        logic [15:0] ea;
        clear_log();
        start_enc(16'h1000);
        for (int i = 0; i < 16; i++) blk[i] = (i % 2 == 0) ? 16'h0007 : 16'hFFF8;
        send_block(1'b0, 1'b0);
        wait_writes(9);
        for (int k = 0; k < 9; k++) begin
            ea = 16'h1000 + 16'(k);
            exp_bytes[k] = (k == 0) ? 8'h00 : 8'h78;
            checks++;
            if (wr_addr[k] !== ea || wr_data[k] !== exp_bytes[k]) begin
                errors++;
                $display("FAIL alternating_byte%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea, exp_bytes[k]);
            end
        end
        checks++;
        if (wr_cyc[8] !== accept_cyc + 10) begin errors++; $display("FAIL alternating_latency: got %0d required %0d", wr_cyc[8] - accept_cyc, 10); end
        @(negedge clock); #1;
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL alternating_ready: got %b required 1", sample_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL alternating_no_done: got %b required 0", done); end
        checks++; if (block_count !== 8'd1) begin errors++; $display("FAIL alternating_count: got %0d required 1", block_count); end
        for (int i = 0; i < 16; i++) blk[i] = 16'h0000;
        send_block(1'b1, 1'b0);
        wait_writes(18);
        checks++;
        if (wr_addr[9] !== 16'h1009 || wr_data[9] !== 8'h01) begin
            errors++;
            $display("FAIL alternating_next_header: got %h=%h required 1009=01", wr_addr[9], wr_data[9]);
        end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1 || block_count !== 8'd2) begin errors++; $display("FAIL alternating_end: got done=%b count=%0d required done=1 count=2", done, block_count); end
        $display("test_alternating complete");
    endtask

    task automatic test_saturate();
        logic [15:0] ea;
        clear_log();
        start_enc(16'h3000);
        for (int i = 0; i < 16; i++) blk[i] = 16'h7FFF;
        send_block(1'b1, 1'b1);
        wait_writes(9);
        for (int k = 0; k < 9; k++) begin
            ea = 16'h3000 + 16'(k);
            exp_bytes[k] = (k == 0) ? 8'hC3 : 8'h77;
            checks++;
            if (wr_addr[k] !== ea || wr_data[k] !== exp_bytes[k]) begin
                errors++;
                $display("FAIL saturate_pos_byte%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea, exp_bytes[k]);
            end
        end
        checks++;
        if (wr_cyc[8] !== accept_cyc + 22) begin errors++; $display("FAIL saturate_latency: got %0d required %0d", wr_cyc[8] - accept_cyc, 22); end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL saturate_pos_done: got %b required 1", done); end
        clear_log();
        start_enc(16'h4000);
        for (int i = 0; i < 16; i++) blk[i] = 16'h8000;
        send_block(1'b1, 1'b0);
        wait_writes(9);
        for (int k = 0; k < 9; k++) begin
            ea = 16'h4000 + 16'(k);
            exp_bytes[k] = (k == 0) ? 8'hC1 : 8'h88;
            checks++;
            if (wr_addr[k] !== ea || wr_data[k] !== exp_bytes[k]) begin
                errors++;
                $display("FAIL saturate_neg_byte%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea, exp_bytes[k]);
            end
        end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL saturate_neg_done: got %b required 1", done); end
        $display("test_saturate complete");
    endtask

    task automatic test_single_peak();
        logic [15:0] ea;
        clear_log();
        start_enc(16'hFFFC);
        for (int i = 0; i < 16; i++) blk[i] = 16'h0000;
        blk[0] = 16'd100;
        send_block(1'b1, 1'b0);
        wait_writes(9);
        for (int k = 0; k < 9; k++) begin
            ea = 16'hFFFC + 16'(k);
            exp_bytes[k] = (k == 0) ? 8'h41 : (k == 1) ? 8'h60 : 8'h00;
            checks++;
            if (wr_addr[k] !== ea || wr_data[k] !== exp_bytes[k]) begin
                errors++;
                $display("FAIL single_peak_byte%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea, exp_bytes[k]);
            end
        end
        checks++;
        if (wr_cyc[8] !== accept_cyc + 14) begin errors++; $display("FAIL single_peak_latency: got %0d required %0d", wr_cyc[8] - accept_cyc, 14); end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1 || block_count !== 8'd1) begin errors++; $display("FAIL single_peak_end: got done=%b count=%0d required done=1 count=1", done, block_count); end
        $display("test_single_peak complete");
    endtask

    task automatic test_reset_midwrite();
        logic [15:0] ea;
        clear_log();
        start_enc(16'h5000);
        for (int i = 0; i < 16; i++) blk[i] = 16'h0000;
        send_block(1'b0, 1'b0);
        wait_writes(4);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock); #1;
        checks++; if (ram_write_request !== 1'b0) begin errors++; $display("FAIL midreset_wr: got %b required 0", ram_write_request); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
        checks++; if (ram_address !== 16'h0000 || block_count !== 8'd0) begin errors++; $display("FAIL midreset_values: got addr=%h count=%0d required addr=0000 count=0", ram_address, block_count); end
        repeat (20) @(negedge clock);
        #1;
        checks++; if (wr_addr.size() !== 4) begin errors++; $display("FAIL midreset_no_writes: got %0d writes required 4", wr_addr.size()); end
        clear_log();
        start_enc(16'h6000);
        for (int i = 0; i < 16; i++) blk[i] = 16'h0010;
        send_block(1'b1, 1'b0);
        wait_writes(9);
        for (int k = 0; k < 9; k++) begin
            ea = 16'h6000 + 16'(k);
            exp_bytes[k] = (k == 0) ? 8'h21 : 8'h44;
            checks++;
            if (wr_addr[k] !== ea || wr_data[k] !== exp_bytes[k]) begin
                errors++;
                $display("FAIL restart_byte%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea, exp_bytes[k]);
            end
        end
        checks++;
        if (wr_cyc[8] !== accept_cyc + 12) begin errors++; $display("FAIL restart_latency: got %0d required %0d", wr_cyc[8] - accept_cyc, 12); end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1 || block_count !== 8'd1) begin errors++; $display("FAIL restart_end: got done=%b count=%0d required done=1 count=1", done, block_count); end
        $display("test_reset_midwrite complete");
    endtask

    task automatic test_start_ignored();
        logic [15:0] ea;
        clear_log();
        start_enc(16'h7000);
        for (int i = 0; i < 16; i++) blk[i] = 16'(i - 8);
        for (int i = 0; i < 8; i++) drive_sample(blk[i], 1'b0, 1'b0);
        // Gap with no valid sample; a start pulse lands inside it.
        for (int g = 0; g < 3; g++) begin
            @(negedge clock); #1;
            checks++;
            if (sample_ready !== 1'b1 || ram_write_request !== 1'b0 || ram_address !== 16'h6008 || ram_wdata !== 8'h44) begin
                errors++;
                $display("FAIL gap%0d: got ready=%b wr=%b addr=%h data=%h required ready=1 wr=0 addr=6008 data=44", g, sample_ready, ram_write_request, ram_address, ram_wdata);
            end
            start = (g == 0);
            start_address = 16'h1234;
        end
        start = 1'b0;
        for (int i = 8; i < 16; i++) drive_sample(blk[i], 1'b0, 1'b0);
        wait_writes(3);
        start = 1'b1;
        start_address = 16'h1234;
        @(posedge clock); #1;
        start = 1'b0;
        wait_writes(9);
        exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h89; exp_bytes[2] = 8'hAB;
        exp_bytes[3] = 8'hCD; exp_bytes[4] = 8'hEF; exp_bytes[5] = 8'h01;
        exp_bytes[6] = 8'h23; exp_bytes[7] = 8'h45; exp_bytes[8] = 8'h67;
        for (int k = 0; k < 9; k++) begin
            ea = 16'h7000 + 16'(k);
            checks++;
            if (wr_addr[k] !== ea || wr_data[k] !== exp_bytes[k]) begin
                errors++;
                $display("FAIL ramp_byte%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea, exp_bytes[k]);
            end
        end
        @(negedge clock); #1;
        checks++; if (block_count !== 8'd1 || sample_ready !== 1'b1) begin errors++; $display("FAIL ramp_status: got count=%0d ready=%b required count=1 ready=1", block_count, sample_ready); end
        for (int i = 0; i < 16; i++) blk[i] = 16'h0000;
        send_block(1'b1, 1'b0);
        wait_writes(18);
        checks++;
        if (wr_addr[9] !== 16'h7009 || wr_data[9] !== 8'h01) begin
            errors++;
            $display("FAIL ramp_next_header: got %h=%h required 7009=01", wr_addr[9], wr_data[9]);
        end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1 || block_count !== 8'd2) begin errors++; $display("FAIL ramp_end: got done=%b count=%0d required done=1 count=2", done, block_count); end
        $display("test_start_ignored complete");
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        start_address = 16'h0000;
        sample_in     = 16'h0000;
        sample_valid  = 1'b0;
        last_block    = 1'b0;
        loop_flag     = 1'b0;
        test_reset();
        test_zero_block();
        test_alternating();
        test_saturate();
        test_single_peak();
        test_reset_midwrite();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/brr_block_encoder.md
BRR_BLOCK_ENCODER -- requirements
Module: brr_block_encoder

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: start  in  1  begin encoding in IDLE; start_address  in  16  first RAM byte address, latched on start.
REQ-003 SHALL have ports: sample_in  in  16  signed PCM sample; sample_valid  in  1  sample present; sample_ready  out  1  encoder accepts a sample.
REQ-004 SHALL have ports: last_block  in  1  block is final; loop_flag  in  1  loop bit for final block; both sampled on the 16th accepted sample of a block.
REQ-005 SHALL have ports: ram_address  out  16  write address; ram_wdata  out  8  write byte; ram_write_request  out  1  one-cycle write strobe, no backpressure.
REQ-006 SHALL have ports: busy  out  1  not IDLE; done  out  1  one-cycle pulse after final block written; block_count  out  8  blocks written since start, wraps at 256.

Function
REQ-007 SHALL implement states IDLE, COLLECT, SEARCH, WRITE_HEADER, WRITE_DATA.
REQ-008 IDLE: start=1 SHALL latch start_address into a 16-bit write pointer, clear block_count, enter COLLECT next cycle; start outside IDLE SHALL be ignored.
REQ-009 COLLECT: sample_ready SHALL be 1; sample accepted when sample_valid & sample_ready; sample_ready SHALL be 0 in every other state.
REQ-010 COLLECT SHALL store 16 samples in arrival order and track running signed max and min of the block; max/min SHALL reinitialize at each block's first sample.
REQ-011 On the 16th accepted sample SHALL latch last_block and loop_flag and enter SEARCH next cycle.
REQ-012 SEARCH SHALL start at shift s=0; each cycle, if (max >>> s) <= 7 and (min >>> s) >= -8, or s == 12, SHALL go to WRITE_HEADER keeping s; else s <= s+1. SEARCH duration 1..13 cycles.
REQ-013 Shifts SHALL be arithmetic; filter field SHALL always be 0 (no prediction).
REQ-014 Header byte SHALL be {s[3:0], 2'b00, loop_bit, end_bit}; end_bit = latched last_block; loop_bit = latched last_block & latched loop_flag.
REQ-015 WRITE_HEADER: one cycle with ram_write_request=1, ram_address=pointer, ram_wdata=header; pointer increments by 1.
REQ-016 WRITE_DATA: 8 consecutive cycles, byte k (0..7) = {nib(2k), nib(2k+1)}, earlier sample in bits [7:4]; ram_write_request=1 each cycle, pointer increments each byte.
REQ-017 nib(i) SHALL be low 4 bits of clamp(sample_i >>> s, -8, 7); clamp only takes effect at s=12 overflow.
REQ-018 After byte 7, block_count SHALL increment; if end_bit=1: IDLE next cycle with done=1 for exactly that cycle; else COLLECT.
REQ-019 Pointer SHALL wrap 0xFFFF -> 0x0000 without error.
REQ-020 Block latency from 16th sample accept to last data write SHALL be (SEARCH cycles) + 9.
REQ-021 ram_write_request SHALL be 0 in IDLE, COLLECT, SEARCH; ram_address/ram_wdata hold last value when not writing.

Reset
REQ-022 Reset SHALL force IDLE next cycle from any state, aborting any block without further writes.
REQ-023 Reset values: sample_ready=0, ram_write_request=0, ram_address=0, ram_wdata=0, busy=0, done=0, block_count=0, s=0, pointer=0.
REQ-024 Reset has priority over start and sample_valid in the same cycle.

Verification
REQ-025 start, start_address=0x0200; 16 zero samples, last_block=1, loop_flag=0 -> writes 0x0200=0x01, 0x0201..0x0208=0x00, done pulse, block_count=1, busy=0.
REQ-026 Samples alternating 7,-8, last_block=0 -> SEARCH 1 cycle, header 0x00, data 0x78 x8, sample_ready=1 again, next header at +9.
REQ-027 16 samples of 0x7FFF, last_block=1, loop_flag=1 -> shift 12, header 0xC3, data bytes 0x77; 16 samples of 0x8000 -> header 0xC1 (loop_flag=0), data 0x88.
REQ-028 Sample0=100, rest 0, last_block=1 -> shift 4 (SEARCH 5 cycles), header 0x41, byte0 0x60, bytes1..7 0x00.
REQ-029 reset asserted during 3rd WRITE_DATA cycle -> ram_write_request=0 next cycle, busy=0, no further writes; new start encodes cleanly.
REQ-030 start pulsed during COLLECT and WRITE_DATA -> ignored; pointer and block_count unaffected; sample_valid=0 gaps in COLLECT -> no acceptance, output unchanged.
